alu_sub: RTL and testbench
==========================

Name: alu_sub

Overview:
- Sequential signed subtractor for the 8-bit ALU arithmetic group; computes diff = a - b with the same start/done handshake as the adder.
- Bit-serial borrow-ripple datapath, one result bit per clock, LSB first, which keeps area small.
- Produces a sign-extended result of width 2*WIDTH plus borrow, overflow, zero and negative flags for the ALU status path.

Parameters:
WIDTH, 8, operand width in bits (>=2); result width is 2*WIDTH.

Ports:
clk  input  1  clock; all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
a  input  WIDTH  signed minuend; must be valid only on the edge start is accepted.
b  input  WIDTH  signed subtrahend; same validity rule as a.
diff  output  2*WIDTH  signed result, sign-extended; held until next completion.
borrow  output  1  unsigned borrow out of the WIDTH-bit subtraction (a < b unsigned).
overflow  output  1  signed WIDTH-bit overflow (the true result does not fit in WIDTH bits).
zero  output  1  true result == 0.
negative  output  1  true result < 0.
busy  output  1  high while state != IDLE.
done  output  1  one-cycle completion pulse.

Behaviour:
- Interface: reset is synchronous and active-high; clock is clk.
- Reset: state=IDLE; diff=0; borrow, overflow, zero, negative, done all 0; internal shift registers, counter and borrow flop cleared.
- Reset mid-operation aborts immediately with no done pulse, and every output returns to its reset value.
- FSM states:
  - IDLE: on an edge with start=1:
    - latch {a[W-1],a} into A and {b[W-1],b} into B (WIDTH+1-bit sign-extended operands);
    - cnt=0, br=0, state->CALC;
    - else stay in IDLE.
  - CALC: each edge performs one serial step:
    - d = A[0]^B[0]^br;
    - br <= (~A[0]&B[0]) | (~(A[0]^B[0])&br);
    - A, B shift right; d shifts into the MSB of the R (WIDTH+1 bits) accumulator;
    - on the step with cnt==WIDTH-1, capture the new br into borrow_int;
    - cnt++; after the step with cnt==WIDTH (WIDTH+1 steps total), state->FIN.
  - FIN: one edge:
    - diff <= {{(WIDTH-1){R[W]}},R};
    - borrow <= borrow_int;
    - overflow <= R[W]^R[W-1];
    - zero <= (R==0);
    - negative <= R[W];
    - done <= 1; state->IDLE.
  - Any other encoding goes to IDLE.
- done is cleared on every edge where it was not set by FIN, so it is high for exactly one cycle.
- Latency: start accepted at edge E0; CALC edges are E1..E(W+1); FIN is edge E(W+2); done is high between E(W+2) and E(W+3). For WIDTH=8, done appears 10 edges after acceptance.
- Arithmetic: the result is exact; the range -(2^W-1)..(2^W-1) always fits in WIDTH+1 bits, so diff never wraps.
- start while busy (CALC/FIN) is ignored; the operands in flight are unaffected.
- Back-to-back operation: if start is high on the edge after FIN (state IDLE, done high), a new operation is accepted on that edge. done still deasserts on that edge.
- diff and the flags change only at FIN or reset; they are stable while busy.
- The a/b inputs may change freely after the accept edge.

Test Plan:
- Reset, then a=5, b=3, start one cycle:
  - busy rises after the accept edge;
  - done pulses after 10 edges;
  - diff=16'h0002, borrow=0, overflow=0, zero=0, negative=0.
- a=3, b=5 -> diff=16'hFFFE, borrow=1, negative=1, overflow=0, zero=0.
- a=-128, b=127 -> diff=16'hFF01, overflow=1, borrow=0, negative=1.
- a=127, b=-128 -> diff=16'h00FF, overflow=1, borrow=1, negative=0.
- a=b=8'h5A -> diff=0, zero=1, all other flags 0.
- Start (a=5, b=3), assert start again with a=1, b=1 at CALC cycle 3, then assert reset at CALC cycle 5:
  - the second start is ignored;
  - on reset, all outputs go to 0 with no done pulse.
- After reset, run a=10, b=20 with start held high continuously:
  - first done gives diff=16'hFFF6;
  - a second operation is accepted on the done edge;
  - done pulses again exactly 10 edges later;
  - done is never high for two consecutive cycles.

Source files
------------

// File: rtl/alu_sub.sv
// alu_sub: bit-serial signed subtractor for the ALU arithmetic group.
// Borrow-ripple datapath, one result bit per clock, LSB first.
module alu_sub #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] diff,
  output logic               borrow,
  output logic               overflow,
  output logic               zero,
  output logic               negative,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH:0] opa;
  logic [WIDTH:0] opb;
  logic [WIDTH:0] r;
  logic [CW-1:0]  cnt;
  logic           br;
  logic           borrow_int;
  logic           d;
  logic           br_next;
  logic           last_step;

  assign d         = opa[0] ^ opb[0] ^ br;
  assign br_next   = (~opa[0] & opb[0]) | (~(opa[0] ^ opb[0]) & br);
  assign last_step = (cnt == CW'(WIDTH));
  assign busy      = (state != IDLE);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // next-state: WIDTH+1 serial steps, then one result-commit cycle
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_step) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // serial datapath and registered results; done is a single-cycle pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      opa        <= '0;
      opb        <= '0;
      r          <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      borrow_int <= 1'b0;
      diff       <= '0;
      borrow     <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
      negative   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            opa <= {a[WIDTH-1], a};
            opb <= {b[WIDTH-1], b};
            cnt <= '0;
            br  <= 1'b0;
          end
        end
        CALC: begin
          br  <= br_next;
          opa <= {1'b0, opa[WIDTH:1]};
          opb <= {1'b0, opb[WIDTH:1]};
          r   <= {d, r[WIDTH:1]};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) borrow_int <= br_next;
        end
        FIN: begin
          diff     <= {{(WIDTH-1){r[WIDTH]}}, r};
          borrow   <= borrow_int;
          overflow <= r[WIDTH] ^ r[WIDTH-1];
          zero     <= (r == '0);
          negative <= r[WIDTH];
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sub.sv
// tb_alu_sub: scoreboard bench for alu_sub.
// Driver queues expected results; monitor checks on each done pulse.
module tb_alu_sub;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] diff;
  logic        borrow;
  logic        overflow;
  logic        zero;
  logic        negative;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic prev_done = 1'b0;

  typedef struct {
    logic [15:0] diff;
    logic        br;
    logic        ov;
    logic        z;
    logic        n;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  alu_sub #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow),
    .zero     (zero),
    .negative (negative),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // monitor: compare every done pulse against the scoreboard head
  always @(negedge clk) begin
    if (done) begin
      chk("done_single_cycle", 16'(prev_done), 16'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 16'd1, 16'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency", 16'(cyc), 16'(e.cyc));
        chk("diff", diff, e.diff);
        chk("borrow", 16'(borrow), 16'(e.br));
        chk("overflow", 16'(overflow), 16'(e.ov));
        chk("zero", 16'(zero), 16'(e.z));
        chk("negative", 16'(negative), 16'(e.n));
      end
    end
    prev_done = done;
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_diff"}, diff, 16'h0000);
    chk({tag, "_flags"}, 16'({borrow, overflow, zero, negative}), 16'd0);
    chk({tag, "_done"}, 16'(done), 16'd0);
    chk({tag, "_busy"}, 16'(busy), 16'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("timeout_idle", 16'd1, 16'd0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout_done", 16'(sb.size()), 16'd0);
      sb.delete();
    end
  endtask

  task automatic op(input logic [7:0] xa, input logic [7:0] xb,
                    input logic [15:0] xd, input logic xbr,
                    input logic xov, input logic xz, input logic xn);
    exp_t e;
    wait_idle();
    @(negedge clk);
    a = xa;
    b = xb;
    start = 1'b1;
    e.diff = xd;
    e.br = xbr;
    e.ov = xov;
    e.z = xz;
    e.n = xn;
    e.cyc = cyc + 11;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    chk("busy_after_accept", 16'(busy), 16'd1);
    wait_drain();
  endtask

  initial begin
    exp_t e;
    int c0;
    int n;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;

    op(8'd5,   8'd3,   16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    op(8'd3,   8'd5,   16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1);
    op(8'h80,  8'h7F,  16'hFF01, 1'b0, 1'b1, 1'b0, 1'b1);
    op(8'h5A,  8'h5A,  16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    op(8'h00,  8'h80,  16'h0080, 1'b1, 1'b1, 1'b0, 1'b0);
    op(8'hFF,  8'h01,  16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    op(8'h7F,  8'h80,  16'h00FF, 1'b1, 1'b1, 1'b0, 1'b0);

    // abort: second start ignored, reset mid-CALC kills the operation
    wait_idle();
    @(negedge clk);
    a = 8'd5;
    b = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'd1;
    b = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_mid_calc", 16'(busy), 16'd1);
    chk("diff_stable_busy", diff, 16'h00FF);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_outputs("abort");
    reset = 1'b0;
    for (int i = 0; i < 14; i++) @(negedge clk);
    chk("abort_idle", 16'(busy), 16'd0);

    // start held high: back-to-back accept on the done edge
    @(negedge clk);
    a = 8'd10;
    b = 8'd20;
    start = 1'b1;
    c0 = cyc;
    e.diff = 16'hFFF6;
    e.br = 1'b1;
    e.ov = 1'b0;
    e.z = 1'b0;
    e.n = 1'b1;
    e.cyc = c0 + 11;
    sb.push_back(e);
    e.cyc = c0 + 22;
    sb.push_back(e);
    n = 0;
    while (cyc < c0 + 22 && n < 40) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    wait_drain();
    for (int i = 0; i < 14; i++) @(negedge clk);
    chk("b2b_no_third", 16'(busy), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
